// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared defaults and state encoding for the eight-way round-robin encoder arbiter.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = $clog2(ARB_N);
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_encoder_arbiter_if.sv
// Requester-side bundle of the arbiter: enable, request levels and the registered grant outputs.
interface rr_encoder_arbiter_if
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
);

  logic             en;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_encoder_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set, non-excluded req bit at or after start.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     excl,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int               p;
    logic [IDX_W-1:0] pos;
    idx   = '0;
    found = 1'b0;
    p     = 0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      p   = (int'(start) + i) % N;
      pos = IDX_W'(p);
      if (!found && req[pos] && !excl[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Eight-way round-robin arbiter with one-hot and encoded registered grant.
// Optional grant-hold limit enabled by defining ARB_TIMEOUT_EN.
module rr_encoder_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = ARB_IDX_W
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = ARB_MAX_HOLD
`endif
) (
  input logic                 clk,
  input logic                 rst,
  rr_encoder_arbiter_if.slave bus
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     gnt_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_valid_r;

  logic [IDX_W-1:0] pick_start;
  logic [N-1:0]     pick_excl;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_r;
`endif

  function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] k);
    return (k == IDX_W'(N - 1)) ? '0 : k + 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // While granted, the search starts after the owner and skips it so a revoked owner is not re-picked.
  always_comb begin
    pick_start = ptr;
    pick_excl  = '0;
    if (state == GRANT) begin
      pick_start = succ(gnt_idx_r);
      pick_excl  = onehot(gnt_idx_r);
    end
  end

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .start (pick_start),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_r       <= '0;
      gnt_idx_r   <= '0;
      gnt_valid_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_r   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.en && pick_found) begin
            state       <= GRANT;
            gnt_r       <= onehot(pick_idx);
            gnt_idx_r   <= pick_idx;
            gnt_valid_r <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        GRANT: begin
          if (!bus.en) begin
            // Pre-emption leaves ptr alone so the owner keeps its priority.
            state       <= IDLE;
            gnt_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_valid_r <= 1'b0;
          end else if (!bus.req[gnt_idx_r]) begin
            ptr <= succ(gnt_idx_r);
            if (pick_found) begin
              gnt_r       <= onehot(pick_idx);
              gnt_idx_r   <= pick_idx;
`ifdef ARB_TIMEOUT_EN
              hold_cnt    <= '0;
`endif
            end else begin
              state       <= IDLE;
              gnt_r       <= '0;
              gnt_idx_r   <= '0;
              gnt_valid_r <= 1'b0;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
              // A lone requester keeps the grant; the count simply restarts.
              hold_cnt <= '0;
              if (pick_found) begin
                ptr       <= succ(gnt_idx_r);
                gnt_r     <= onehot(pick_idx);
                gnt_idx_r <= pick_idx;
                timeout_r <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`endif
          end
        end
        default: begin
          state       <= IDLE;
          gnt_r       <= '0;
          gnt_idx_r   <= '0;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_r;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed-vector bench for rr_encoder_arbiter; timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_rr_encoder_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  rr_encoder_arbiter_if #(.N(8), .IDX_W(3)) bus ();

  rr_encoder_arbiter #(
    .N     (8),
    .IDX_W (3)
`ifdef ARB_TIMEOUT_EN
    ,
    .MAX_HOLD (4)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};

  // Expected {gnt, gnt_idx, gnt_valid, timeout} for a hand-chosen owner index.
  function automatic logic [13:0] expv(input int idx, input bit v, input bit to);
    logic [7:0] g;
    logic [2:0] ix;
    g  = v ? (8'h01 << idx) : 8'h00;
    ix = v ? 3'(idx) : 3'd0;
    return {g, ix, v, to};
  endfunction

  task automatic test_reset();
    logic [13:0] e;
    rst = 1'b1; bus.en = 1'b1; bus.req = 8'hFF;
    @(negedge clk); @(negedge clk);
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_hold got %h want %h", obs, e); end
    rst = 1'b0;
    @(negedge clk);
    e = expv(0, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_first_grant got %h want %h", obs, e); end
  endtask

  task automatic test_rotate();
    logic [13:0] e;
    for (int k = 0; k < 8; k++) begin
      bus.req = 8'hFF;
      @(negedge clk);
      e = expv(k, 1, 0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rotate_hold k=%0d got %h want %h", k, obs, e); end
      bus.req = 8'hFF & ~(8'h01 << k);
      @(negedge clk);
      e = expv((k + 1) % 8, 1, 0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rotate_next k=%0d got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_wrap();
    logic [13:0] e;
    bus.req = 8'h20;
    @(negedge clk);
    e = expv(5, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL wrap_setup got %h want %h", obs, e); end
    bus.req = 8'h00;
    @(negedge clk);
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL wrap_idle got %h want %h", obs, e); end
    bus.req = 8'b0000_0101;
    @(negedge clk);
    e = expv(0, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL wrap_to_0 got %h want %h", obs, e); end
    bus.req = 8'b0000_0100;
    @(negedge clk);
    e = expv(2, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL wrap_then_2 got %h want %h", obs, e); end
    bus.req = 8'h00;
    @(negedge clk);
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL wrap_release got %h want %h", obs, e); end
  endtask

  task automatic test_enable();
    logic [13:0] e;
    bus.req = 8'b0000_1001;
    @(negedge clk);
    e = expv(3, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL en_grant3 got %h want %h", obs, e); end
    bus.en = 1'b0;
    @(negedge clk);
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL en_low_drop got %h want %h", obs, e); end
    bus.en = 1'b1;
    @(negedge clk);
    e = expv(3, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL en_regrant3 got %h want %h", obs, e); end
    bus.en = 1'b0; bus.req = 8'h10;
    @(negedge clk);
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL en_low_with_release got %h want %h", obs, e); end
    @(negedge clk);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL en_low_idle got %h want %h", obs, e); end
    bus.en = 1'b1; bus.req = 8'h18;
    @(negedge clk);
    e = expv(3, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL en_ptr_kept got %h want %h", obs, e); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [13:0] e;
    bus.req = 8'h00;
    @(negedge clk);
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL to_idle got %h want %h", obs, e); end
    bus.req = 8'h03;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        e = expv(r % 2, 1, (c == 0 && r > 0));
        vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL to_rotate r=%0d c=%0d got %h want %h", r, c, obs, e); end
      end
    end
    bus.req = 8'h20;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      e = expv(5, 1, 0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL to_lone c=%0d got %h want %h", c, obs, e); end
    end
  endtask
`else
  task automatic test_hold();
    logic [13:0] e;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = expv(3, 1, 0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL hold c=%0d got %h want %h", c, obs, e); end
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [13:0] e;
    bus.req = 8'h18;
    @(negedge clk);
    e = expv(3, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL areset_pre got %h want %h", obs, e); end
    #2 rst = 1'b1;
    #1;
    e = expv(0, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL areset_immediate got %h want %h", obs, e); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    e = expv(3, 1, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL areset_after got %h want %h", obs, e); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.req     = 8'h00;
    test_reset();
    test_rotate();
    test_wrap();
    test_enable();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
